// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with serial slave-ID decode
module bus_arbiter #(
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic                  m1_valid,
  input  logic                  m2_valid,
  input  logic                  m1_addr,
  input  logic                  m2_addr,
  input  logic                  bus_done,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic [NUM_SLAVES-1:0] slave_sel,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(SEL_BITS + 1);
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_BUSY, S_RELEASE} state_t;

  state_t                state, state_n;
  logic                  owner_m2, owner_m2_n;
  logic                  last_m2, last_m2_n;
  logic [SEL_BITS-1:0]   id, id_n, id_shift;
  logic [SEL_BITS:0]     id_ext;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_n;
  logic [NUM_SLAVES-1:0] sel_n;
  logic                  err_n, g1_n, g2_n, busy_n;
  logic                  own_req, own_valid, own_addr, timed_out;

  always_comb begin
    own_req    = owner_m2 ? m2_req   : m1_req;
    own_valid  = owner_m2 ? m2_valid : m1_valid;
    own_addr   = owner_m2 ? m2_addr  : m1_addr;
    id_ext     = {id, own_addr};
    id_shift   = id_ext[SEL_BITS-1:0];
    timed_out  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    state_n    = state;
    owner_m2_n = owner_m2;
    last_m2_n  = last_m2;
    id_n       = id;
    bit_cnt_n  = bit_cnt;
    tmo_cnt_n  = tmo_cnt;
    sel_n      = slave_sel;
    err_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (m1_req || m2_req) begin
          // on a tie the master that did not hold the bus last wins
          owner_m2_n = m2_req && (!m1_req || !last_m2);
          last_m2_n  = owner_m2_n;
          state_n    = S_DECODE;
          id_n       = '0;
          bit_cnt_n  = '0;
          tmo_cnt_n  = '0;
        end
      end
      S_DECODE: begin
        tmo_cnt_n = tmo_cnt + 1'b1;
        if (!own_req) begin
          state_n = S_RELEASE;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = S_RELEASE;
        end else if (own_valid) begin
          id_n      = id_shift;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(SEL_BITS - 1)) begin
            if (int'(id_shift) < NUM_SLAVES) begin
              state_n = S_BUSY;
              sel_n   = NUM_SLAVES'(1) << id_shift;
            end else begin
              err_n   = 1'b1;
              state_n = S_RELEASE;
            end
          end
        end
      end
      S_BUSY: begin
        tmo_cnt_n = tmo_cnt + 1'b1;
        if (bus_done || !own_req) begin
          state_n = S_RELEASE;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = S_RELEASE;
        end
      end
      default: begin
        id_n      = '0;
        bit_cnt_n = '0;
        tmo_cnt_n = '0;
        state_n   = S_IDLE;
      end
    endcase

    if (state_n != S_BUSY) sel_n = '0;
    g1_n   = (state_n == S_DECODE || state_n == S_BUSY) && !owner_m2_n;
    g2_n   = (state_n == S_DECODE || state_n == S_BUSY) &&  owner_m2_n;
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner_m2  <= 1'b0;
      last_m2   <= 1'b1;
      id        <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      slave_sel <= '0;
      m1_grant  <= 1'b0;
      m2_grant  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      owner_m2  <= owner_m2_n;
      last_m2   <= last_m2_n;
      id        <= id_n;
      bit_cnt   <= bit_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
      slave_sel <= sel_n;
      m1_grant  <= g1_n;
      m2_grant  <= g2_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;
  localparam int SB = 2;
  localparam int NS = 3;
  localparam int TO = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic m1_req = 1'b0, m2_req = 1'b0, m1_valid = 1'b0, m2_valid = 1'b0;
  logic m1_addr = 1'b0, m2_addr = 1'b0, bus_done = 1'b0;
  logic m1_grant, m2_grant, busy, err;
  logic [NS-1:0] slave_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.SEL_BITS(SB), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req), .m1_valid(m1_valid), .m2_valid(m2_valid),
    .m1_addr(m1_addr), .m2_addr(m2_addr), .bus_done(bus_done),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .slave_sel(slave_sel),
    .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // phase: 0 idle, 1 collecting ID bits, 2 transferring, 3 release gap
  int  ph, cyc, mid, idv;
  bit  own2, last2, r, v, a;
  int  bits_q[$];
  logic e_g1, e_g2, e_busy, e_err;
  logic [NS-1:0] e_sel;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; own2 = 0; last2 = 1; cyc = 0; mid = 0; bits_q.delete();
      e_g1 = 0; e_g2 = 0; e_busy = 0; e_err = 0; e_sel = '0;
    end else begin
      e_err = 0;
      r = own2 ? m2_req : m1_req;
      v = own2 ? m2_valid : m1_valid;
      a = own2 ? m2_addr : m1_addr;
      case (ph)
        0: if (m1_req || m2_req) begin
          own2  = m2_req && (!m1_req || !last2);
          last2 = own2;
          ph = 1; cyc = 0; bits_q.delete();
        end
        1, 2: begin
          cyc++;
          if (ph == 2 && bus_done) ph = 3;
          else if (!r) ph = 3;
          else if (cyc == TO) begin ph = 3; e_err = 1; end
          else if (ph == 1 && v) begin
            bits_q.push_back(int'(a));
            if (bits_q.size() == SB) begin
              idv = 0;
              foreach (bits_q[i]) idv = idv * 2 + bits_q[i];
              if (idv < NS) begin ph = 2; mid = idv; end
              else begin ph = 3; e_err = 1; end
            end
          end
        end
        default: ph = 0;
      endcase
      e_busy = (ph != 0);
      e_g1   = (ph == 1 || ph == 2) && !own2;
      e_g2   = (ph == 1 || ph == 2) && own2;
      e_sel  = (ph == 2) ? (NS'(1) << mid) : '0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("m1_grant", 32'(m1_grant), 32'(e_g1));
      chk("m2_grant", 32'(m2_grant), 32'(e_g2));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("err", 32'(err), 32'(e_err));
      chk("slave_sel", 32'(slave_sel), 32'(e_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bit1(input logic b);
    m1_valid = 1'b1; m1_addr = b;
    step();
    m1_valid = 1'b0;
  endtask

  task automatic bit2(input logic b);
    m2_valid = 1'b1; m2_addr = b;
    step();
    m2_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("reset_outputs", {27'd0, m1_grant, m2_grant, busy, err, 1'b0}, 32'd0);
    chk("reset_sel", 32'(slave_sel), 32'd0);
    reset = 1'b1;
    step();

    // single request, ID 2
    m1_req = 1'b1;
    step();
    chk("t1_grant", 32'(m1_grant), 32'd1);
    bit1(1'b1); bit1(1'b0);
    chk("t1_sel", 32'(slave_sel), 32'b100);
    step(); step();
    pulse_done();
    chk("t1_release", {30'd0, m1_grant, busy}, 32'b01);
    m1_req = 1'b0;
    step();
    chk("t1_idle", 32'(busy), 32'd0);

    // simultaneous requests from reset
    reset = 1'b0; step(); reset = 1'b1;
    m1_req = 1'b1; m2_req = 1'b1;
    step();
    chk("t2_first_m1", {30'd0, m1_grant, m2_grant}, 32'b10);
    bit1(1'b0); bit1(1'b0);
    chk("t2_sel0", 32'(slave_sel), 32'b001);
    pulse_done();
    m1_req = 1'b0;
    step();
    chk("t2_gap", {30'd0, m2_grant, busy}, 32'b00);
    step();
    chk("t2_then_m2", 32'(m2_grant), 32'd1);
    bit2(1'b0); bit2(1'b1);
    chk("t2_sel1", 32'(slave_sel), 32'b010);
    pulse_done();
    m1_req = 1'b1;
    step(); step();
    chk("t2_tie_m1", {30'd0, m1_grant, m2_grant}, 32'b10);

    // invalid ID 3
    bit1(1'b1); bit1(1'b1);
    chk("t3_err", {28'd0, err, m1_grant, slave_sel != 0, busy}, 32'b1001);
    m1_req = 1'b0; m2_req = 1'b0;
    step();
    chk("t3_err_once", {30'd0, err, busy}, 32'b00);

    // gapped valid bits 0 .. 1
    m1_req = 1'b1;
    step();
    bit1(1'b0);
    m1_addr = 1'b1;
    step(); step(); step();
    bit1(1'b1);
    chk("t4_sel", 32'(slave_sel), 32'b010);
    m1_req = 1'b0;
    step();
    chk("t4_abort", {29'd0, m1_grant, err, busy}, 32'b001);
    step();

    // timeout in DECODE
    m1_req = 1'b1;
    step();
    repeat (15) step();
    chk("t5_before_to", {30'd0, err, m1_grant}, 32'b01);
    step();
    chk("t5_timeout", {29'd0, err, m1_grant, busy}, 32'b101);
    step(); step();
    chk("t5_regrant", 32'(m1_grant), 32'd1);
    bit1(1'b0); bit1(1'b0);
    repeat (13) step();
    pulse_done();
    chk("t5_done_wins", {29'd0, err, m1_grant, busy}, 32'b001);
    m1_req = 1'b0;
    step();

    // abort by m2, then asynchronous reset during BUSY
    m2_req = 1'b1;
    step();
    chk("t6_m2_grant", 32'(m2_grant), 32'd1);
    bit2(1'b1); bit2(1'b0);
    chk("t6_sel2", 32'(slave_sel), 32'b100);
    m2_req = 1'b0;
    step();
    chk("t6_abort", {29'd0, m2_grant, err, busy}, 32'b001);
    step();
    m2_req = 1'b1;
    step();
    bit2(1'b0); bit2(1'b1);
    m1_req = 1'b1;
    step();
    chk("t6_held_off", {30'd0, m1_grant, m2_grant}, 32'b01);
    reset = 1'b0;
    #1;
    chk("t6_async_rst", {26'd0, m1_grant, m2_grant, busy, err, slave_sel != 0, 1'b0}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("t6_after_rst", {30'd0, m1_grant, m2_grant}, 32'b10);
    m1_req = 1'b0; m2_req = 1'b0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and slave selector for the shared serial system bus in front of the BRAM-backed slaves.
- Grants the bus to one requesting master at a time, using round-robin order.
- Decodes the slave ID from the first serial address bits of the granted master and drives a one-hot slave select.
- Holds the grant until the transaction completes, is aborted, or times out; then releases the bus.

Parameters:
- SEL_BITS, 2, number of leading serial address bits (MSB first) that form the slave ID.
- NUM_SLAVES, 3, number of attached slaves; a slave ID >= NUM_SLAVES is invalid.
- TIMEOUT, 1024, maximum cycles allowed in DECODE+BUSY before a forced release.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- m1_req  input  1  master 1 bus request; level, held for the whole transaction.
- m2_req  input  1  master 2 bus request.
- m1_valid  input  1  master 1 address/data bit valid strobe.
- m2_valid  input  1  master 2 valid strobe.
- m1_addr  input  1  master 1 serial address line.
- m2_addr  input  1  master 2 serial address line.
- bus_done  input  1  one-cycle completion pulse; OR of all slaves' rx_done/slave_tx_done.
- m1_grant  output  1  master 1 owns the bus.
- m2_grant  output  1  master 2 owns the bus.
- slave_sel  output  NUM_SLAVES  one-hot slave select; valid only in BUSY.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on invalid slave ID or timeout.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grants, slave_sel, busy and err all 0; bit counter=0; timeout counter=0; last_grant=m2, so m1 wins the first tie.
- All outputs are registered.
- IDLE:
  - One request pending: grant that master next cycle.
  - Both pending: grant the master not equal to last_grant.
  - Go to DECODE with grant=1 and busy=1; update last_grant.
- DECODE:
  - On each cycle where the granted master's valid=1, shift its addr bit into the ID register, MSB first, and increment the bit counter.
  - valid=0 cycles are ignored (no shift).
  - After SEL_BITS bits, branch:
    - ID < NUM_SLAVES: go to BUSY; slave_sel[ID]=1 on the next cycle.
    - Invalid ID: pulse err, go to RELEASE.
- BUSY:
  - slave_sel and grant are held stable.
  - bus_done=1: go to RELEASE.
- RELEASE:
  - Lasts exactly one cycle; grants=0, slave_sel=0, counters cleared, busy stays 1.
  - Then IDLE; no back-to-back grant without a RELEASE gap.
- Abort: if the granted master drops req in DECODE or BUSY, go to RELEASE next cycle; no err.
- Timeout:
  - The counter runs in DECODE and BUSY and clears on entering DECODE.
  - When it reaches TIMEOUT-1: pulse err, go to RELEASE.
  - Priority when events coincide in the same cycle: bus_done > abort > timeout.
- bus_done outside BUSY is ignored.
- The non-granted master's request is held off; it is serviced after RELEASE, per round-robin order.
- Mid-transaction reset returns everything to the reset values immediately, asynchronously.

Test Plan:
- Single request: m1_req=1, valid bits 1,0 → m1_grant=1 one cycle after req; slave_sel=3'b100 (slave 2) after 2 valid bits; bus_done pulse → grant falls, RELEASE 1 cycle, then IDLE.
- Simultaneous requests: m1_req=m2_req=1 from reset → m1 granted first; after its bus_done, m2 granted after one RELEASE cycle; next tie goes to m1 again.
- Invalid ID: granted master sends bits 1,1 with NUM_SLAVES=3 → err pulses for exactly 1 cycle; slave_sel never asserts; bus released.
- Gapped valid: bits 0 and 1 delivered with 3 valid=0 cycles between them → ID=1, slave_sel=3'b010.
- Timeout: TIMEOUT=16, no bus_done → err at cycle 16 after DECODE entry, grant dropped; bus_done together with the timeout cycle → no err.
- Abort and reset: m2 drops req in BUSY → RELEASE next cycle, no err; reset asserted in BUSY → all outputs 0 asynchronously, first grant after reset goes to m1.
